// File: rtl/car_sprite_plotter.sv
// Erase-then-draw pixel streamer for an 8x8 car sprite into the 160x120 VGA adapter.
// One output register stage aligns pixel coordinates with the synchronous ROM.
module car_sprite_plotter #(
    parameter int                  SB           = 3,
    parameter int                  COLOUR_W     = 3,
    parameter logic [COLOUR_W-1:0] ERASE_COLOUR = 3'b000,
    parameter int                  SCREEN_W     = 160,
    parameter int                  SCREEN_H     = 120
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Start,
    input  logic [7:0]          NewX,
    input  logic [6:0]          NewY,
    output logic                Busy,
    output logic                Done,
    output logic [2*SB-1:0]     RomAddr,
    input  logic [COLOUR_W-1:0] RomData,
    output logic [7:0]          VGA_X,
    output logic [6:0]          VGA_Y,
    output logic [COLOUR_W-1:0] Colour,
    output logic                Plot
);

    localparam int AW = 2 * SB;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERASE,
        S_DRAW,
        S_FLUSH,
        S_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic [7:0]      cur_x_q, cur_x_d;
    logic [6:0]      cur_y_q, cur_y_d;
    logic [7:0]      old_x_q, old_x_d;
    logic [6:0]      old_y_q, old_y_d;
    logic            have_old_q, have_old_d;
    logic [7:0]      vga_x_q, vga_x_d;
    logic [6:0]      vga_y_q, vga_y_d;
    logic            plot_q, plot_d;
    logic            erase_q, erase_d;
    logic            draw_q, draw_d;

    logic [SB-1:0]   col;
    logic [SB-1:0]   row;
    logic [7:0]      base_x;
    logic [6:0]      base_y;
    logic [8:0]      px_x;
    logic [7:0]      px_y;
    logic            issue;
    logic            last;

    assign col    = cnt_q[SB-1:0];
    assign row    = cnt_q[AW-1:SB];
    assign last   = &cnt_q;
    assign issue  = (state_q == S_ERASE) || (state_q == S_DRAW);
    assign base_x = (state_q == S_ERASE) ? old_x_q : cur_x_q;
    assign base_y = (state_q == S_ERASE) ? old_y_q : cur_y_q;
    assign px_x   = {1'b0, base_x} + 9'(col);
    assign px_y   = {1'b0, base_y} + 8'(row);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            cur_x_q    <= '0;
            cur_y_q    <= '0;
            old_x_q    <= '0;
            old_y_q    <= '0;
            have_old_q <= 1'b0;
            vga_x_q    <= '0;
            vga_y_q    <= '0;
            plot_q     <= 1'b0;
            erase_q    <= 1'b0;
            draw_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cur_x_q    <= cur_x_d;
            cur_y_q    <= cur_y_d;
            old_x_q    <= old_x_d;
            old_y_q    <= old_y_d;
            have_old_q <= have_old_d;
            vga_x_q    <= vga_x_d;
            vga_y_q    <= vga_y_d;
            plot_q     <= plot_d;
            erase_q    <= erase_d;
            draw_q     <= draw_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cur_x_d    = cur_x_q;
        cur_y_d    = cur_y_q;
        old_x_d    = old_x_q;
        old_y_d    = old_y_q;
        have_old_d = have_old_q;
        // Off-screen pixels still occupy their slot; only the strobe is dropped
        plot_d     = issue && (px_x < 9'(SCREEN_W)) && (px_y < 8'(SCREEN_H));
        vga_x_d    = issue ? px_x[7:0] : '0;
        vga_y_d    = issue ? px_y[6:0] : '0;
        erase_d    = (state_q == S_ERASE);
        draw_d     = (state_q == S_DRAW);

        unique case (state_q)
            S_IDLE: begin
                if (Start) begin
                    cur_x_d = NewX;
                    cur_y_d = NewY;
                    cnt_d   = '0;
                    state_d = have_old_q ? S_ERASE : S_DRAW;
                end
            end
            S_ERASE: begin
                cnt_d = cnt_q + 1'b1;
                if (last) state_d = S_DRAW;
            end
            S_DRAW: begin
                cnt_d = cnt_q + 1'b1;
                if (last) state_d = S_FLUSH;
            end
            S_FLUSH: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                old_x_d    = cur_x_q;
                old_y_d    = cur_y_q;
                have_old_d = 1'b1;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign RomAddr = cnt_q;
    assign Busy    = (state_q == S_ERASE) || (state_q == S_DRAW) ||
                     (state_q == S_FLUSH);
    assign Done    = (state_q == S_DONE);
    assign VGA_X   = vga_x_q;
    assign VGA_Y   = vga_y_q;
    assign Plot    = plot_q;
    // ROM word arrives in the same cycle as its registered coordinates
    assign Colour  = draw_q  ? RomData :
                     erase_q ? ERASE_COLOUR : '0;

endmodule

// File: tb/tb_car_sprite_plotter.sv
// Scoreboard bench for car_sprite_plotter: expected pixels are queued at each
// request and popped against every Plot strobe; Busy/Done checked per cycle.
module tb_car_sprite_plotter;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       Start = 1'b0;
    logic [7:0] NewX  = '0;
    logic [6:0] NewY  = '0;
    logic       Busy;
    logic       Done;
    logic [5:0] RomAddr;
    logic [2:0] RomData;
    logic [7:0] VGA_X;
    logic [6:0] VGA_Y;
    logic [2:0] Colour;
    logic       Plot;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    pix_t       sb_q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;
    bit         have_old = 1'b0;
    logic [7:0] old_x = '0;
    logic [6:0] old_y = '0;

    car_sprite_plotter dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .Start   (Start),
        .NewX    (NewX),
        .NewY    (NewY),
        .Busy    (Busy),
        .Done    (Done),
        .RomAddr (RomAddr),
        .RomData (RomData),
        .VGA_X   (VGA_X),
        .VGA_Y   (VGA_Y),
        .Colour  (Colour),
        .Plot    (Plot)
    );

    always #10 Clock = ~Clock;

    always @(posedge Clock) cyc <= cyc + 1;

    function automatic logic [2:0] rom_fn(logic [5:0] a);
        return a[2:0] ^ {a[4:3], a[5]} ^ 3'd5;
    endfunction

    always @(posedge Clock) RomData <= rom_fn(RomAddr);

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push_run(logic [7:0] x, logic [6:0] y);
        int px;
        int py;
        if (have_old) begin
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 8; c++) begin
                    px = int'(old_x) + c;
                    py = int'(old_y) + r;
                    if (px < 160 && py < 120)
                        sb_q.push_back('{8'(px), 7'(py), 3'b000});
                end
        end
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                px = int'(x) + c;
                py = int'(y) + r;
                if (px < 160 && py < 120)
                    sb_q.push_back('{8'(px), 7'(py), rom_fn(6'(r * 8 + c))});
            end
        old_x    = x;
        old_y    = y;
        have_old = 1'b1;
    endtask

    always @(negedge Clock) begin
        pix_t e;
        if (Plot === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("extra_plot", 32'(VGA_X), 32'hFFFF);
            end else begin
                e = sb_q.pop_front();
                check("px_x", 32'(VGA_X), 32'(e.x));
                check("px_y", 32'(VGA_Y), 32'(e.y));
                check("px_colour", 32'(Colour), 32'(e.c));
            end
        end
    end

    task automatic run(logic [7:0] x, logic [6:0] y, int glitch, int rstc,
                       int rst_left);
        int done_c;
        done_c = have_old ? 130 : 66;
        @(negedge Clock);
        Start = 1'b1;
        NewX  = x;
        NewY  = y;
        push_run(x, y);
        @(posedge Clock);
        #1;
        Start = 1'b0;
        NewX  = ~x;
        NewY  = ~y;
        for (int c = 1; c <= done_c + 1; c++) begin
            @(negedge Clock);
            check("busy", 32'(Busy), 32'(c < done_c));
            check("done", 32'(Done), 32'(c == done_c));
            if (glitch > 0 && c == glitch) begin
                Start = 1'b1;
                NewX  = x + 8'd50;
            end
            if (glitch > 0 && c == glitch + 1) Start = 1'b0;
            if (c == rstc) begin
                Reset = 1'b1;
                @(negedge Clock);
                check("rst_plot", 32'(Plot), 0);
                check("rst_busy", 32'(Busy), 0);
                check("rst_left", sb_q.size(), rst_left);
                Reset = 1'b0;
                sb_q.delete();
                have_old = 1'b0;
                return;
            end
        end
        check("sb_empty", sb_q.size(), 0);
    endtask

    initial begin
        int t1;
        int t2;
        Reset = 1'b1;
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        check("rst_busy0", 32'(Busy), 0);
        check("rst_done0", 32'(Done), 0);
        check("rst_plot0", 32'(Plot), 0);
        check("rst_x0", 32'(VGA_X), 0);
        check("rst_y0", 32'(VGA_Y), 0);
        check("rst_col0", 32'(Colour), 0);
        check("rst_addr0", 32'(RomAddr), 0);
        Reset = 1'b0;
        repeat (2) @(negedge Clock);

        run(8'd75, 7'd70, 0, 0, 0);
        run(8'd40, 7'd70, 0, 0, 0);
        run(8'd156, 7'd116, 0, 0, 0);
        run(8'd20, 7'd10, 30, 0, 0);
        run(8'd60, 7'd30, 0, 85, 44);
        repeat (2) @(negedge Clock);
        run(8'd90, 7'd50, 0, 0, 0);

        @(negedge Clock);
        Start = 1'b1;
        NewX  = 8'd30;
        NewY  = 7'd40;
        push_run(8'd30, 7'd40);
        push_run(8'd30, 7'd40);
        t1 = -1;
        t2 = -1;
        for (int c = 0; c < 400 && t2 < 0; c++) begin
            @(negedge Clock);
            if (Done === 1'b1) begin
                if (t1 < 0) begin
                    t1 = cyc;
                end else begin
                    t2    = cyc;
                    Start = 1'b0;
                end
            end
        end
        Start = 1'b0;
        check("done_gap", 32'(t2 - t1), 131);
        repeat (3) @(negedge Clock);
        check("hold_sb", sb_q.size(), 0);
        check("hold_idle", 32'(Busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/car_sprite_plotter.md
Name: car_sprite_plotter

Overview:
- Pixel-stream generator between the lane/position controller and the VGA adapter, drawing in 160x120 mode.
- On each position request it erases the car's previous 8x8 footprint with the erase colour, then draws the sprite at the new (x,y). Sprite pixels are read from the synchronous car ROM.
- Emits one (x, y, colour, plot) pixel per clock and reports Busy and Done to the controller.

Parameters:
- SB, 3, log2 of sprite side; sprite is 2^SB x 2^SB and ROM address is {row, col}, 2*SB bits.
- COLOUR_W, 3, colour width.
- ERASE_COLOUR, 3'b000, colour used to erase the old footprint.
- SCREEN_W, 160, visible width; pixels with x >= SCREEN_W are suppressed.
- SCREEN_H, 120, visible height; pixels with y >= SCREEN_H are suppressed.

Ports:
- Clock  in  1  system clock (50 MHz).
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  position request; sampled only in IDLE.
- NewX  in  8  sprite top-left x.
- NewY  in  7  sprite top-left y.
- Busy  out  1  high in ERASE, DRAW and FLUSH.
- Done  out  1  one-cycle completion pulse.
- RomAddr  out  2*SB  sprite ROM address {row, col}.
- RomData  in  COLOUR_W  ROM colour; valid one clock after RomAddr.
- VGA_X  out  8  pixel x to the adapter.
- VGA_Y  out  7  pixel y to the adapter.
- Colour  out  COLOUR_W  pixel colour to the adapter.
- Plot  out  1  write strobe to the adapter.

Behaviour:
- Clocking and reset: one clock, one synchronous active-high reset. Reset drives every output to 0 (Busy, Done, Plot, VGA_X, VGA_Y, Colour, RomAddr), the state to IDLE, the pixel counter to 0 and HaveOld to 0.
- Reset mid-operation:
  - Aborts immediately; the next cycle shows Plot=0.
  - The partially drawn footprint is not cleaned up.
  - HaveOld=0, so the next request skips ERASE.
- States: IDLE, ERASE, DRAW, FLUSH, DONE.
- IDLE:
  - Start=1 latches NewX/NewY into CurX/CurY and clears the counter.
  - Goes to ERASE if HaveOld=1, otherwise to DRAW.
  - Start is ignored in every other state; no queuing.
- Pixel counter:
  - 2*SB bits, row-major, col in the low SB bits (col fastest). RomAddr = counter.
  - ERASE and DRAW each issue 2^(2*SB) addresses, 64 by default, one per cycle.
  - ERASE->DRAW on counter wrap, with no bubble.
  - DRAW->FLUSH on wrap. FLUSH lasts 1 cycle, then DONE for 1 cycle with Done=1, then IDLE.
- Output stage, one register stage to match the ROM latency:
  - The pixel issued at cycle t appears on VGA_X/VGA_Y/Colour/Plot at cycle t+1.
  - ERASE pixels use OldX/OldY and Colour=ERASE_COLOUR.
  - DRAW pixels use CurX/CurY and Colour=RomData.
- Coordinate arithmetic:
  - x = base_x + col computed 9 bits wide; y = base_y + row computed 8 bits wide.
  - Plot=1 only when x < SCREEN_W and y < SCREEN_H. Suppressed pixels still consume their cycle.
  - VGA_X/VGA_Y carry the low 8/7 bits regardless of Plot.
- Completion: in DONE, OldX/OldY <= CurX/CurY and HaveOld <= 1.
- Timing, with Start accepted at edge 0 and HaveOld=1:
  - ERASE occupies cycles 1..64; erase pixels appear at cycles 2..65.
  - DRAW occupies cycles 65..128; draw pixels appear at cycles 66..129.
  - FLUSH is cycle 129, Done=1 at cycle 130, IDLE from cycle 131.
  - Busy is high for cycles 1..129.
- Timing with HaveOld=0: DRAW occupies cycles 1..64, FLUSH is cycle 65, Done=1 at cycle 66.
- Plot is 0 in IDLE and DONE.
- NewX/NewY changing while Busy has no effect.

Test Plan:
- Reset, then Start with NewX=75, NewY=70 -> no erase; 64 Plot cycles at cycles 2..65 covering x 75..82, y 70..77 in row-major order; Colour equals the ROM word for {row,col}; Done at cycle 66.
- Second Start with NewX=40, NewY=70 -> 64 pixels of colour 000 over x 75..82, then 64 ROM pixels over x 40..47; Done exactly at cycle 130; Busy high for cycles 1..129.
- Start with NewX=156, NewY=116 -> Plot=1 only for cols 0..3 and rows 0..3 (16 pixels); the counter still runs all 64 cycles; Done timing is unchanged.
- Pulse Start at cycle 30 of ERASE with different NewX -> ignored; the run completes at the original position; OldX equals the first-latched NewX.
- Assert Reset during DRAW at counter=20 -> Plot=0 and Busy=0 next cycle; the next Start draws immediately with no ERASE phase.
- Hold Start high continuously -> a new run begins at the IDLE cycle after each Done; Done pulses are separated by 131 cycles.
